fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the MIPS datapath. It owns the program counter and sequences requests to instruction memory over a req/ack handshake.
- It presents each fetched word, with its PC, to decode over a valid/ready handshake.
- It handles branch/jump redirects, including redirects that arrive while a memory request is in flight, and it halts on misaligned targets.

Parameters:
RESET_PC, 32'h00400020, PC value loaded on reset (first fetch address)
PC_STEP, 4, byte increment between sequential fetches

Ports:
clock  input  1  system clock; all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
redirect_valid  input  1  branch/jump taken this cycle
redirect_addr  input  32  branch/jump target byte address
mem_req  output  1  instruction memory request (registered)
mem_addr  output  32  byte address of request; stable while mem_req=1
mem_ack  input  1  memory has returned mem_rdata this cycle
mem_rdata  input  32  instruction word from memory
instr_valid  output  1  instr/instr_pc hold a valid instruction
instr  output  32  fetched instruction word
instr_pc  output  32  byte address of instr
instr_ready  input  1  decode accepts instr this cycle
misalign_fault  output  1  sticky; redirect target had addr[1:0]!=0
fetch_count  output  32  number of instructions accepted by decode

Behaviour:
- reset_n=0 (async):
  - state=START; pc=RESET_PC; redirect_pend=0.
  - mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0, misalign_fault=0, fetch_count=0.
- States: START, FETCH, HOLD, HALT.
- START: unconditional transition to FETCH next cycle with mem_req<=1, mem_addr<=pc. The first request is visible 1 cycle after reset release.
- FETCH:
  - mem_req=1 and mem_addr are held constant until a cycle with mem_ack=1.
  - On mem_ack with redirect_pend=0: instr<=mem_rdata, instr_pc<=mem_addr, instr_valid<=1, pc<=mem_addr+PC_STEP, mem_req<=0, go to HOLD.
  - On mem_ack with redirect_pend=1: discard data, instr_valid stays 0, redirect_pend<=0, mem_addr<=pc (the redirect target), mem_req stays 1, stay in FETCH.
  - Aligned redirect_valid without mem_ack: pc<=redirect_addr, redirect_pend<=1. mem_addr is not changed; the request is never abandoned.
  - Aligned redirect_valid in the same cycle as mem_ack: treated as a pending redirect. Data is discarded and the next request goes to redirect_addr.
  - A later redirect while pending: overwrites pc (last target wins).
- HOLD:
  - instr_valid=1; instr and instr_pc are stable until accepted.
  - instr_ready=1, no redirect: instr_valid<=0, mem_req<=1, mem_addr<=pc, go to FETCH.
  - Aligned redirect_valid: instr_valid<=0, pc<=redirect_addr, mem_req<=1, mem_addr<=redirect_addr, go to FETCH.
  - If instr_ready=1 in the same redirect cycle, the instruction counts as accepted; otherwise it is squashed uncounted.
- Misaligned redirect (redirect_addr[1:0]!=0) in any of FETCH/HOLD:
  - misalign_fault<=1, mem_req<=0, instr_valid<=0, go to HALT.
  - Takes priority over mem_ack and instr_ready in that cycle.
- HALT: all inputs ignored; outputs frozen. Exit only via reset_n.
- redirect_valid in START or HALT: ignored.
- fetch_count: +1 on each cycle with instr_valid&instr_ready (state HOLD). Wraps modulo 2^32.
- PC arithmetic: 32-bit modulo. 32'hFFFFFFFC+4 = 32'h00000000, with no flag.
- Throughput: at most one instruction per 2 cycles. Latency with single-cycle ack: request at cycle N, instr_valid at cycle N+1.
- Reset asserted mid-request or mid-hold: immediate return to reset values. Any in-flight ack after release is ignored in START.

Test Plan:
- Reset release, memory acks the cycle after each req, instr_ready=1 always -> mem_addr sequence 0x00400020, 0x00400024, 0x00400028; instr_pc matches each; fetch_count=3 after 3 acceptances.
- Memory ack delayed 3 cycles, instr_ready low 2 cycles in HOLD -> mem_addr and instr remain stable throughout; no duplicate or dropped fetch; fetch_count increments once.
- Redirect to 0x00400100 one cycle before ack of 0x00400024 -> returned word discarded (instr_valid stays 0); next mem_addr=0x00400100; delivered instr_pc=0x00400100.
- In HOLD, redirect to 0x00400200 with instr_ready=0 -> instr squashed, fetch_count unchanged, next mem_addr=0x00400200. Repeat with instr_ready=1 -> fetch_count +1.
- Redirect to 0x00400102 -> misalign_fault=1 next cycle, mem_req=0, instr_valid=0; further redirects/acks ignored. Pulse reset_n low -> fault clears, pc=0x00400020.
- Redirect to 0xFFFFFFFC, ack -> instr_pc=0xFFFFFFFC, next mem_addr=0x00000000. Assert reset_n low mid-FETCH -> mem_req drops to 0 asynchronously.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues req/ack fetches to instruction memory
// and hands each word with its PC to decode over valid/ready, honouring branch redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0020,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        misalign_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {StStart, StFetch, StHold, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        redirect_pend_q, redirect_pend_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        fault_q, fault_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic redirect_misaligned;
    logic redirect_aligned;

    assign redirect_misaligned = redirect_valid && (redirect_addr[1:0] != 2'b00);
    assign redirect_aligned    = redirect_valid && (redirect_addr[1:0] == 2'b00);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StStart;
            pc_q            <= RESET_PC;
            redirect_pend_q <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_addr_q      <= 32'd0;
            instr_valid_q   <= 1'b0;
            instr_q         <= 32'd0;
            instr_pc_q      <= 32'd0;
            fault_q         <= 1'b0;
            fetch_count_q   <= 32'd0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            redirect_pend_q <= redirect_pend_d;
            mem_req_q       <= mem_req_d;
            mem_addr_q      <= mem_addr_d;
            instr_valid_q   <= instr_valid_d;
            instr_q         <= instr_d;
            instr_pc_q      <= instr_pc_d;
            fault_q         <= fault_d;
            fetch_count_q   <= fetch_count_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        redirect_pend_d = redirect_pend_q;
        mem_req_d       = mem_req_q;
        mem_addr_d      = mem_addr_q;
        instr_valid_d   = instr_valid_q;
        instr_d         = instr_q;
        instr_pc_d      = instr_pc_q;
        fault_d         = fault_q;
        fetch_count_d   = fetch_count_q;

        unique case (state_q)
            StStart: begin
                mem_req_d  = 1'b1;
                mem_addr_d = pc_q;
                state_d    = StFetch;
            end

            StFetch: begin
                if (redirect_misaligned) begin
                    fault_d       = 1'b1;
                    mem_req_d     = 1'b0;
                    instr_valid_d = 1'b0;
                    state_d       = StHalt;
                end else if (mem_ack) begin
                    if (redirect_pend_q || redirect_aligned) begin
                        // Word belongs to the wrong path: drop it and re-issue at the target.
                        redirect_pend_d = 1'b0;
                        pc_d            = redirect_aligned ? redirect_addr : pc_q;
                        mem_addr_d      = redirect_aligned ? redirect_addr : pc_q;
                    end else begin
                        instr_d       = mem_rdata;
                        instr_pc_d    = mem_addr_q;
                        instr_valid_d = 1'b1;
                        pc_d          = mem_addr_q + PC_STEP;
                        mem_req_d     = 1'b0;
                        state_d       = StHold;
                    end
                end else if (redirect_aligned) begin
                    // Request stays in flight; the target is remembered until its ack.
                    pc_d            = redirect_addr;
                    redirect_pend_d = 1'b1;
                end
            end

            StHold: begin
                if (redirect_misaligned) begin
                    fault_d       = 1'b1;
                    mem_req_d     = 1'b0;
                    instr_valid_d = 1'b0;
                    state_d       = StHalt;
                end else if (redirect_aligned) begin
                    if (instr_ready) begin
                        fetch_count_d = fetch_count_q + 32'd1;
                    end
                    instr_valid_d = 1'b0;
                    pc_d          = redirect_addr;
                    mem_req_d     = 1'b1;
                    mem_addr_d    = redirect_addr;
                    state_d       = StFetch;
                end else if (instr_ready) begin
                    fetch_count_d = fetch_count_q + 32'd1;
                    instr_valid_d = 1'b0;
                    mem_req_d     = 1'b1;
                    mem_addr_d    = pc_q;
                    state_d       = StFetch;
                end
            end

            StHalt: begin
                state_d = StHalt;
            end

            default: begin
                state_d = StHalt;
            end
        endcase
    end

    assign mem_req        = mem_req_q;
    assign mem_addr       = mem_addr_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign misalign_fault = fault_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed stimulus pushes expected request addresses and
// delivered PCs; a negedge monitor pops and compares on each ack and each decode acceptance.
module tb_fetch_sequencer;

    logic        clock;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        misalign_fault;
    logic [31:0] fetch_count;

    localparam logic [31:0] DataKey = 32'hC0DE_0000;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_req[$];
    logic [31:0] exp_pc[$];

    // Memory content is a fixed function of the address.
    assign mem_rdata = mem_addr ^ DataKey;

    fetch_sequencer #(
        .RESET_PC(32'h0040_0020),
        .PC_STEP (32'd4)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .misalign_fault(misalign_fault),
        .fetch_count   (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops plus hold-stability checks on both handshakes.
    logic        p_rst, p_req, p_ack, p_valid, p_ready, p_redir;
    logic [31:0] p_addr, p_instr, p_pc;
    initial begin
        p_rst = 1'b0; p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0;
        p_ready = 1'b0; p_redir = 1'b0; p_addr = '0; p_instr = '0; p_pc = '0;
    end

    always @(negedge clock) begin
        logic [31:0] e;
        if (reset_n) begin
            if (mem_req && mem_ack) begin
                if (exp_req.size() == 0) begin
                    check("unexpected_ack_req", mem_addr, 32'hxxxx_xxxx);
                end else begin
                    e = exp_req.pop_front();
                    check("req_addr", mem_addr, e);
                end
            end
            if (instr_valid && instr_ready) begin
                if (exp_pc.size() == 0) begin
                    check("unexpected_accept", instr_pc, 32'hxxxx_xxxx);
                end else begin
                    e = exp_pc.pop_front();
                    check("instr_pc", instr_pc, e);
                    check("instr_word", instr, e ^ DataKey);
                end
            end
            if (p_rst && p_req && !p_ack && mem_req) begin
                check("mem_addr_stable", mem_addr, p_addr);
            end
            if (p_rst && p_valid && !p_ready && !p_redir && instr_valid) begin
                check("instr_stable", instr, p_instr);
                check("instr_pc_stable", instr_pc, p_pc);
            end
        end
        p_rst   = reset_n;
        p_req   = mem_req;
        p_ack   = mem_ack;
        p_valid = instr_valid;
        p_ready = instr_ready;
        p_redir = redirect_valid;
        p_addr  = mem_addr;
        p_instr = instr;
        p_pc    = instr_pc;
    end

    task automatic step(input logic ack, input logic rdy, input logic rv,
                        input logic [31:0] ra);
        mem_ack        = ack;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_addr  = ra;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        mem_ack        = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        reset_n        = 1'b0;
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_fault", misalign_fault, 1'b0);
        check("rst_count", fetch_count, 32'd0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        mem_ack = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
        reset_n = 1'b0;
        @(posedge clock);
        #1;

        // Sequential fetch, single-cycle ack, decode always ready.
        do_reset();
        exp_req.push_back(32'h0040_0020); exp_pc.push_back(32'h0040_0020);
        exp_req.push_back(32'h0040_0024); exp_pc.push_back(32'h0040_0024);
        exp_req.push_back(32'h0040_0028); exp_pc.push_back(32'h0040_0028);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 32'd0);
        check("t1_count", fetch_count, 32'd3);
        check("t1_next_addr", mem_addr, 32'h0040_002C);

        // Slow memory and stalled decode.
        do_reset();
        exp_req.push_back(32'h0040_0020); exp_pc.push_back(32'h0040_0020);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
        check("t2_still_req", mem_req, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("t2_count_before", fetch_count, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        check("t2_count", fetch_count, 32'd1);
        check("t2_next_addr", mem_addr, 32'h0040_0024);

        // Redirect while the 0x24 request is in flight.
        do_reset();
        exp_req.push_back(32'h0040_0020); exp_pc.push_back(32'h0040_0020);
        exp_req.push_back(32'h0040_0024);
        exp_req.push_back(32'h0040_0100); exp_pc.push_back(32'h0040_0100);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0040_0100);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("t3_discard_valid", instr_valid, 1'b0);
        check("t3_redir_addr", mem_addr, 32'h0040_0100);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        check("t3_count", fetch_count, 32'd2);

        // Redirect in HOLD: squashed without ready, counted with ready.
        do_reset();
        exp_req.push_back(32'h0040_0020);
        exp_req.push_back(32'h0040_0200); exp_pc.push_back(32'h0040_0200);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0040_0200);
        check("t4_squash_count", fetch_count, 32'd0);
        check("t4_squash_valid", instr_valid, 1'b0);
        check("t4_squash_addr", mem_addr, 32'h0040_0200);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'h0040_0200);
        check("t4_accept_count", fetch_count, 32'd1);
        check("t4_accept_addr", mem_addr, 32'h0040_0200);

        // Misaligned redirect halts until reset.
        do_reset();
        exp_req.push_back(32'h0040_0020);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0040_0102);
        check("t5_fault", misalign_fault, 1'b1);
        check("t5_req", mem_req, 1'b0);
        check("t5_valid", instr_valid, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 32'h0040_0300);
        check("t5_fault_sticky", misalign_fault, 1'b1);
        check("t5_req_frozen", mem_req, 1'b0);
        check("t5_addr_frozen", mem_addr, 32'h0040_0020);
        check("t5_pc_frozen", instr_pc, 32'h0040_0020);
        check("t5_count", fetch_count, 32'd0);
        do_reset();
        exp_req.push_back(32'h0040_0020);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("t5_restart_req", mem_req, 1'b1);
        check("t5_restart_addr", mem_addr, 32'h0040_0020);
        step(1'b1, 1'b0, 1'b0, 32'd0);

        // PC wrap at the top of the address space, then async reset mid-fetch.
        do_reset();
        exp_req.push_back(32'h0040_0020);
        exp_req.push_back(32'hFFFF_FFFC); exp_pc.push_back(32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("t6_hold_pc", instr_pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        check("t6_wrap_addr", mem_addr, 32'h0000_0000);
        check("t6_wrap_req", mem_req, 1'b1);
        reset_n = 1'b0;
        #1;
        check("t6_async_req", mem_req, 1'b0);
        @(posedge clock);
        #1;

        check("req_queue_left", exp_req.size(), 32'd0);
        check("pc_queue_left", exp_pc.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
